// File: rtl/rr_grant_arbiter_if.sv
// Request/grant bundle between the requesters and the round-robin grant arbiter.
// master = requester side, slave = arbiter side.
interface rr_grant_arbiter_if #(
    parameter int N  = 4,
    parameter int IW = 2
);
    logic [N-1:0]  req;
    logic [N-1:0]  gnt;
    logic          gnt_valid;
    logic [IW-1:0] gnt_idx;
    logic          any_req;
    logic          timeout;

    modport master (output req, input gnt, gnt_valid, gnt_idx, any_req, timeout);
    modport slave  (input req, output gnt, gnt_valid, gnt_idx, any_req, timeout);
endinterface

// File: rtl/rr_grant_arbiter.sv
// Round-robin arbiter with grant hold: one registered one-hot grant, held while the
// owner keeps requesting, force-rotated after MAX_HOLD cycles when others are waiting.
module rr_grant_arbiter #(
    parameter int N        = 4,
    parameter int MAX_HOLD = 8,
    parameter int IW       = 2,
    parameter int CW       = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    rr_grant_arbiter_if.slave bus
);
    if (N < 2 || MAX_HOLD < 1 || (1 << IW) < N || (MAX_HOLD - 1) >= (1 << CW)) begin : g_bad_param
        $error("rr_grant_arbiter: illegal parameters N=%0d MAX_HOLD=%0d IW=%0d CW=%0d",
               N, MAX_HOLD, IW, CW);
    end

    typedef enum logic {IDLE, GRANT} state_t;

    localparam logic [CW-1:0] HOLD_LAST = CW'(MAX_HOLD - 1);

    state_t        state;
    logic [N-1:0]  gnt_q;
    logic          gnt_valid_q;
    logic [IW-1:0] gnt_idx_q;
    logic [IW-1:0] ptr;
    logic [CW-1:0] cnt;
    logic          any_req_q;
    logic          timeout_q;

    logic [N-1:0]  cand;
    logic [N-1:0]  pick_oh;
    logic [IW-1:0] pick_idx;
    logic [IW-1:0] scan_idx;
    logic          pick_found;

    // While granting, ptr equals the owner; masking the owner makes every re-pick
    // search the other requesters starting just after it.
    always_comb begin
        cand       = (state == GRANT) ? (bus.req & ~gnt_q) : bus.req;
        pick_found = 1'b0;
        pick_idx   = '0;
        scan_idx   = '0;
        // Scan farthest-first so the nearest hit after ptr is the one that sticks.
        for (int off = N; off >= 1; off--) begin
            scan_idx = IW'((int'(ptr) + off) % N);
            if (cand[scan_idx]) begin
                pick_found = 1'b1;
                pick_idx   = scan_idx;
            end
        end
        pick_oh           = '0;
        pick_oh[pick_idx] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            gnt_q       <= '0;
            gnt_valid_q <= 1'b0;
            gnt_idx_q   <= '0;
            ptr         <= IW'(N - 1);
            cnt         <= '0;
            any_req_q   <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            any_req_q <= |bus.req;
            timeout_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick_found) begin
                        state       <= GRANT;
                        gnt_q       <= pick_oh;
                        gnt_valid_q <= 1'b1;
                        gnt_idx_q   <= pick_idx;
                        ptr         <= pick_idx;
                        cnt         <= '0;
                    end
                end
                GRANT: begin
                    if (!bus.req[ptr]) begin
                        cnt <= '0;
                        if (pick_found) begin
                            gnt_q     <= pick_oh;
                            gnt_idx_q <= pick_idx;
                            ptr       <= pick_idx;
                        end else begin
                            state       <= IDLE;
                            gnt_q       <= '0;
                            gnt_valid_q <= 1'b0;
                            gnt_idx_q   <= '0;
                        end
                    end else if (cnt == HOLD_LAST) begin
                        // Hold limit reached: rotate only if someone else is waiting,
                        // otherwise stay put with the counter pinned at the limit.
                        if (pick_found) begin
                            gnt_q     <= pick_oh;
                            gnt_idx_q <= pick_idx;
                            ptr       <= pick_idx;
                            cnt       <= '0;
                            timeout_q <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.gnt_valid = gnt_valid_q;
    assign bus.gnt_idx   = gnt_idx_q;
    assign bus.any_req   = any_req_q;
    assign bus.timeout   = timeout_q;
endmodule

// File: tb/tb_rr_grant_arbiter.sv
// Self-checking bench for rr_grant_arbiter: directed scenarios plus a randomized run
// against a behavioural owner/pointer model.
module tb_rr_grant_arbiter;
    localparam int N        = 4;
    localparam int MAX_HOLD = 8;
    localparam int IW       = 2;
    localparam int CW       = 4;
    localparam int WAIT_MAX = (N - 1) * MAX_HOLD + 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    // Reference model: who owns the grant, where the round-robin pointer sits, how long
    // the owner has held, and the expected one-cycle flags.
    int   m_owner;
    int   m_ptr;
    int   m_hold;
    logic m_any;
    logic m_to;

    rr_grant_arbiter_if #(.N(N), .IW(IW)) bus ();

    rr_grant_arbiter #(.N(N), .MAX_HOLD(MAX_HOLD), .IW(IW), .CW(CW)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    function automatic int rr_pick(input logic [N-1:0] r, input int start, input int excl);
        for (int k = 1; k <= N; k++) begin
            int c;
            c = (start + k) % N;
            if (c != excl && r[c]) return c;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] exp_gnt();
        logic [N-1:0] one;
        one = 1;
        return (m_owner < 0) ? '0 : (one << m_owner);
    endfunction

    task automatic model_reset();
        m_owner = -1;
        m_ptr   = N - 1;
        m_hold  = 0;
        m_any   = 1'b0;
        m_to    = 1'b0;
    endtask

    task automatic model_edge(input logic [N-1:0] r);
        int nxt;
        m_any = |r;
        m_to  = 1'b0;
        if (m_owner < 0) begin
            nxt = rr_pick(r, m_ptr, -1);
            if (nxt >= 0) begin
                m_owner = nxt; m_ptr = nxt; m_hold = 0;
            end
        end else if (!r[m_owner]) begin
            nxt     = rr_pick(r, m_owner, m_owner);
            m_owner = nxt;
            m_hold  = 0;
            if (nxt >= 0) m_ptr = nxt;
        end else if (m_hold >= MAX_HOLD - 1) begin
            nxt = rr_pick(r, m_owner, m_owner);
            if (nxt >= 0) begin
                m_owner = nxt; m_ptr = nxt; m_hold = 0; m_to = 1'b1;
            end
        end else begin
            m_hold++;
        end
    endtask

    // One clock: drive req, let the edge sample it, settle 1 time unit past the edge.
    task automatic tick(input logic [N-1:0] r);
        bus.req = r;
        @(posedge clk);
        model_edge(r);
        #1;
    endtask

    task automatic apply_reset();
        bus.req = '0;
        rst_n   = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        bus.req = '0;
        rst_n   = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({bus.gnt, bus.gnt_valid, bus.gnt_idx, bus.any_req, bus.timeout} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: gnt=%b valid=%b idx=%0d any=%b to=%b, required all zero",
                     bus.gnt, bus.gnt_valid, bus.gnt_idx, bus.any_req, bus.timeout);
        end
        rst_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick('0);
            checks++;
            if (bus.gnt !== '0 || bus.gnt_valid !== 1'b0 || bus.any_req !== 1'b0) begin
                errors++;
                $display("FAIL idle_no_req cycle %0d: gnt=%b valid=%b any=%b, required 0/0/0",
                         c, bus.gnt, bus.gnt_valid, bus.any_req);
            end
        end
    endtask

    task automatic test_single();
        for (int c = 1; c <= 4; c++) begin
            tick(4'b0100);
            checks++;
            if (bus.gnt !== 4'b0100 || bus.gnt_valid !== 1'b1 || bus.gnt_idx !== 2'd2 ||
                bus.any_req !== 1'b1) begin
                errors++;
                $display("FAIL single_grant cycle %0d: gnt=%b valid=%b idx=%0d any=%b, required 0100/1/2/1",
                         c, bus.gnt, bus.gnt_valid, bus.gnt_idx, bus.any_req);
            end
        end
        tick('0);
        checks++;
        if (bus.gnt !== '0 || bus.gnt_valid !== 1'b0 || bus.any_req !== 1'b0) begin
            errors++;
            $display("FAIL single_release: gnt=%b valid=%b any=%b, required 0000/0/0",
                     bus.gnt, bus.gnt_valid, bus.any_req);
        end
    endtask

    task automatic test_async_reset();
        tick(4'b0010);
        tick(4'b0010);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.gnt, bus.gnt_valid, bus.gnt_idx, bus.any_req, bus.timeout} !== '0) begin
            errors++;
            $display("FAIL async_reset: gnt=%b valid=%b idx=%0d any=%b to=%b, required all zero",
                     bus.gnt, bus.gnt_valid, bus.gnt_idx, bus.any_req, bus.timeout);
        end
        apply_reset();
    endtask

    // Fairness under full load: tenure k belongs to requester k mod N for MAX_HOLD cycles.
    task automatic test_all_hold();
        logic [N-1:0] one;
        int           who;
        logic         to_exp;
        one = 1;
        apply_reset();
        for (int c = 1; c <= 5 * MAX_HOLD; c++) begin
            tick('1);
            who    = ((c - 1) / MAX_HOLD) % N;
            to_exp = (c > 1) && ((c - 1) % MAX_HOLD == 0);
            checks++;
            if (bus.gnt !== (one << who) || bus.gnt_idx !== IW'(who) || bus.timeout !== to_exp) begin
                errors++;
                $display("FAIL all_hold cycle %0d: gnt=%b idx=%0d to=%b, required %b/%0d/%b",
                         c, bus.gnt, bus.gnt_idx, bus.timeout, one << who, who, to_exp);
            end
        end
    endtask

    task automatic test_saturate();
        apply_reset();
        tick(4'b0010);
        for (int c = 0; c < 20; c++) begin
            tick(4'b0010);
            checks++;
            if (bus.gnt !== 4'b0010 || bus.timeout !== 1'b0) begin
                errors++;
                $display("FAIL saturate cycle %0d: gnt=%b to=%b, required 0010/0", c, bus.gnt, bus.timeout);
            end
        end
        // A saturated counter must rotate on the very first competing request.
        tick(4'b1010);
        checks++;
        if (bus.gnt !== 4'b1000 || bus.timeout !== 1'b1) begin
            errors++;
            $display("FAIL saturate_rotate: gnt=%b to=%b, required 1000/1", bus.gnt, bus.timeout);
        end
    endtask

    task automatic test_release_switch();
        apply_reset();
        repeat (3) tick(4'b0001);
        tick(4'b1010);
        checks++;
        if (bus.gnt !== 4'b0010 || bus.gnt_valid !== 1'b1 || bus.gnt_idx !== 2'd1 ||
            bus.timeout !== 1'b0) begin
            errors++;
            $display("FAIL release_switch: gnt=%b valid=%b idx=%0d to=%b, required 0010/1/1/0",
                     bus.gnt, bus.gnt_valid, bus.gnt_idx, bus.timeout);
        end
        tick(4'b1000);
        checks++;
        if (bus.gnt !== 4'b1000 || bus.gnt_idx !== 2'd3) begin
            errors++;
            $display("FAIL release_next: gnt=%b idx=%0d, required 1000/3", bus.gnt, bus.gnt_idx);
        end
    endtask

    task automatic test_random();
        logic [N-1:0] r;
        logic [N-1:0] one;
        int           wait_cnt[N];
        one = 1;
        for (int i = 0; i < N; i++) wait_cnt[i] = 0;
        for (int c = 0; c < 10000; c++) begin
            for (int i = 0; i < N; i++) r[i] = ($urandom_range(3, 0) != 0);
            if ($urandom_range(31, 0) == 0) r = '0;
            tick(r);
            checks++;
            if (bus.gnt !== exp_gnt() || bus.gnt_valid !== (m_owner >= 0) ||
                bus.any_req !== m_any || bus.timeout !== m_to ||
                (m_owner >= 0 && bus.gnt_idx !== IW'(m_owner))) begin
                errors++;
                $display("FAIL random_model cycle %0d req=%b: gnt=%b valid=%b idx=%0d any=%b to=%b, required gnt=%b owner=%0d any=%b to=%b",
                         c, r, bus.gnt, bus.gnt_valid, bus.gnt_idx, bus.any_req, bus.timeout,
                         exp_gnt(), m_owner, m_any, m_to);
            end
            checks++;
            if ($countones(bus.gnt) > 1 || (bus.gnt & ~r) != '0 ||
                (bus.gnt_valid && bus.gnt !== (one << bus.gnt_idx))) begin
                errors++;
                $display("FAIL random_invariant cycle %0d: req=%b gnt=%b valid=%b idx=%0d",
                         c, r, bus.gnt, bus.gnt_valid, bus.gnt_idx);
            end
            for (int i = 0; i < N; i++) begin
                wait_cnt[i] = (r[i] && !bus.gnt[i]) ? wait_cnt[i] + 1 : 0;
                checks++;
                if (wait_cnt[i] > WAIT_MAX) begin
                    errors++;
                    $display("FAIL random_wait cycle %0d: requester %0d waited %0d, limit %0d",
                             c, i, wait_cnt[i], WAIT_MAX);
                    wait_cnt[i] = 0;
                end
            end
        end
    endtask

    initial begin
        bus.req = '0;
        model_reset();
        test_reset();
        test_single();
        test_async_reset();
        test_all_hold();
        test_saturate();
        test_release_switch();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/rr_grant_arbiter.md
Name: rr_grant_arbiter

Overview:
- Round-robin arbiter with grant hold for N requesters, instantiated next to the any-request OR gate.
- Takes a raw request vector and issues one registered one-hot grant.
- Holds the grant while the owner keeps requesting, bounded by a hold timeout.
- Also provides a registered any-request flag and the encoded owner index for the downstream mux.

Parameters:
N, 4, number of requesters (2..16)
MAX_HOLD, 8, max consecutive cycles one owner may hold the grant while others wait (>=1)
IW, 2, width of encoded owner index; must equal clog2(N)
CW, 4, hold-counter width; must hold MAX_HOLD

Ports:
clk  in  1  single system clock, rising edge
rst_n  in  1  asynchronous active-low reset
req  in  N  request vector, one bit per requester, level-sensitive
gnt  out  N  one-hot grant, registered; all-zero when no owner
gnt_valid  out  1  high when gnt is non-zero
gnt_idx  out  IW  encoded owner index; valid only when gnt_valid=1
any_req  out  1  registered OR of req (one-cycle delayed)
timeout  out  1  one-cycle pulse when the hold limit forces a rotation

Behaviour:
- Reset is asynchronous, active-low; one clock domain. While rst_n=0:
  - gnt=0, gnt_valid=0, gnt_idx=0, any_req=0, timeout=0
  - state=IDLE, hold counter=0, RR pointer=N-1, so requester 0 has first priority after reset.
- Reset asserted mid-grant: all outputs clear immediately, without waiting for a clock edge.
- States:
  - IDLE: no owner.
  - GRANT: owner = gnt_idx.
- Pick function:
  - Search from (ptr+1) mod N upward, wrapping.
  - Select the first requester with req=1.
- IDLE transitions:
  - If req!=0 at edge k: gnt=onehot(pick) from edge k+1 (1-cycle latency), ptr=pick, counter=0, go to GRANT.
  - Otherwise stay IDLE.
- GRANT, sampled at each edge:
  - a) req[owner]=0 (release): re-pick among the other requesters. If any, switch directly (no idle bubble), ptr=new owner, counter=0. If none, go to IDLE and gnt=0 next cycle.
  - b) req[owner]=1, counter=MAX_HOLD-1, and any other req=1: forced rotation to pick (owner excluded), counter=0, timeout=1 for exactly that one cycle.
  - c) req[owner]=1, counter=MAX_HOLD-1, no other req: keep the grant; counter saturates at MAX_HOLD-1; no timeout.
  - d) Otherwise: keep the grant; counter+=1.
- Grant exclusivity:
  - Never more than one gnt bit set.
  - gnt changes only on a clock edge.
  - gnt_idx always encodes gnt.
- Fairness:
  - With all N requesting continuously, each requester receives MAX_HOLD-cycle tenures in order 0,1,..,N-1,0.
  - Worst-case wait = (N-1)*MAX_HOLD cycles.
- Simultaneous release and new requests: handled by case (a) at the same edge; the releasing owner is lowest priority in that pick.
- A req bit pulsing for under one cycle between edges is ignored.
- any_req = registered |req, independent of state.
- Counter arithmetic is unsigned CW bits and never wraps, because it saturates.
- Parameter check: elaboration fails if N<2, MAX_HOLD<1, or 2^IW<N.

Test Plan:
- Reset, then req=4'b0000 for 5 cycles -> gnt=0, gnt_valid=0, any_req=0 throughout; assert rst_n mid-grant -> all outputs 0 asynchronously.
- req=4'b0100 at edge 1 -> gnt=4'b0100, gnt_idx=2 from edge 2; drop req at edge 5 -> gnt=0 from edge 6, state IDLE.
- req=4'b1111 held, MAX_HOLD=8 -> grant sequence 0001,0010,0100,1000,0001, each lasting exactly 8 cycles; timeout pulses at every transition.
- Owner 1 holding, req=4'b0010 only, for 20 cycles -> gnt stays 0010, no timeout, counter saturates at 7.
- Owner 0 drops req at the same edge req[3] and req[1] rise -> gnt=0010 next cycle with no bubble; ptr=1; the next pick after 1's release with req[3]=1 -> 1000.
- Random req for 10k cycles with scoreboard:
  - gnt one-hot or zero
  - gnt only to a requester that was requesting
  - no requester waits more than (N-1)*MAX_HOLD+1 cycles
  - gnt_idx matches gnt
